// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the data-miss FSM encoding and the register-index width.
package pipe_ctrl_pkg;

    localparam int REG_W     = 5;
    localparam int MUL_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESUME = 2'd2
    } dmiss_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall bundle between the pipeline stages (master) and the controller (slave).
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] D_rs1;
    logic [REG_W-1:0] D_rs2;
    logic             D_use_rs1;
    logic             D_use_rs2;
    logic [REG_W-1:0] EX_rd;
    logic             EX_ld;
    logic             EX_mul;
    logic             EX_taken_raw;
    logic             MEM_dmiss;
    logic             MEM_fill_done;
    logic             F_imiss;

    logic             stall_F;
    logic             flush_FD;
    logic             stall_D;
    logic             MEM_stall;
    logic             EX_taken;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_ld, EX_mul,
               EX_taken_raw, MEM_dmiss, MEM_fill_done, F_imiss,
        input  stall_F, flush_FD, stall_D, MEM_stall, EX_taken, mul_busy, stall_cycles
    );

    modport slave (
        input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, EX_rd, EX_ld, EX_mul,
               EX_taken_raw, MEM_dmiss, MEM_fill_done, F_imiss,
        output stall_F, flush_FD, stall_D, MEM_stall, EX_taken, mul_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_ctrl_mul.sv
// Multiply occupancy counter: keeps a MUL in EX for MUL_LAT cycles,
// freezing while a data miss holds the back end.
module mul_occupancy_ctr
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ex_mul,
    input  logic i_freeze,
    output logic o_mul_busy
);

    localparam logic [MUL_CNT_W-1:0] LAST = MUL_CNT_W'(MUL_LAT - 1);

    logic [MUL_CNT_W-1:0] r_cnt;

    assign o_mul_busy = rst_n && i_ex_mul && (r_cnt < LAST);

    // Reaching LAST means the MUL advances this edge, so the next MUL starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_ex_mul && !i_freeze) begin
            if (r_cnt < LAST) r_cnt <= r_cnt + 1'b1;
            else              r_cnt <= '0;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: data-miss FSM, load-use detect, multiply
// occupancy and the prioritised hold/bubble/flush outputs for F->D and D->EX.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  bus
);

    dmiss_state_e     r_state;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_mem_hold;
    logic w_mul_busy;
    logic w_mem_stall;
    logic w_load_use;
    logic w_stall_f;
    logic w_flush_fd;
    logic w_stall_d;
    logic w_ex_taken;

    assign w_mem_hold = rst_n && ((r_state == IDLE && bus.MEM_dmiss) || r_state == WAIT);

    mul_occupancy_ctr #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ex_mul   (bus.EX_mul),
        .i_freeze   (w_mem_hold),
        .o_mul_busy (w_mul_busy)
    );

    assign w_mem_stall = w_mem_hold || w_mul_busy;

    assign w_load_use = rst_n && bus.EX_ld && (bus.EX_rd != '0) &&
                        ((bus.D_use_rs1 && bus.D_rs1 == bus.EX_rd) ||
                         (bus.D_use_rs2 && bus.D_rs2 == bus.EX_rd));

    // Back-end hold wins so D->EX is never bubbled or flushed while held;
    // a deferred redirect reappears because the EX instruction stays put.
    always_comb begin
        w_stall_f  = 1'b0;
        w_flush_fd = 1'b0;
        w_stall_d  = 1'b0;
        w_ex_taken = 1'b0;
        if (w_mem_stall) begin
            w_stall_f  = 1'b1;
        end else if (rst_n && bus.EX_taken_raw) begin
            w_ex_taken = 1'b1;
            w_flush_fd = 1'b1;
        end else if (w_load_use) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
        end else if (rst_n && bus.F_imiss) begin
            w_stall_f  = 1'b1;
            w_flush_fd = 1'b1;
        end
    end

    // A miss seen alongside a fill in IDLE wins; a stale miss in RESUME is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.MEM_dmiss)     r_state <= WAIT;
                WAIT:    if (bus.MEM_fill_done) r_state <= RESUME;
                RESUME:                         r_state <= IDLE;
                default:                        r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_stall_cycles <= '0;
        else if (w_stall_f) r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign bus.stall_F      = w_stall_f;
    assign bus.flush_FD     = w_flush_fd;
    assign bus.stall_D      = w_stall_d;
    assign bus.MEM_stall    = w_mem_stall;
    assign bus.EX_taken     = w_ex_taken;
    assign bus.mul_busy     = w_mul_busy;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MUL_LAT=3; output vector order is
// {stall_F, flush_FD, stall_D, MEM_stall, EX_taken, mul_busy}.
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    hazard_stall_ctrl_if #(.CNT_W(32)) bus();

    hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [5:0] outs;
    assign outs = {bus.stall_F, bus.flush_FD, bus.stall_D, bus.MEM_stall, bus.EX_taken, bus.mul_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.D_rs1 = '0; bus.D_rs2 = '0; bus.D_use_rs1 = 0; bus.D_use_rs2 = 0;
        bus.EX_rd = '0; bus.EX_ld = 0; bus.EX_mul = 0; bus.EX_taken_raw = 0;
        bus.MEM_dmiss = 0; bus.MEM_fill_done = 0; bus.F_imiss = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        bus.EX_mul = 1; bus.MEM_dmiss = 1; bus.F_imiss = 1; bus.EX_taken_raw = 1;
        bus.EX_ld = 1; bus.EX_rd = 5'd5; bus.D_rs1 = 5'd5; bus.D_use_rs1 = 1;
        tick(); tick();
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_outs got %b want %b", outs, 6'b000000); end
        n_cmp++;
        if (bus.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cycles); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL post_reset_idle got %b want %b", outs, 6'b000000); end
    endtask

    task automatic test_load_use;
        tick();
        bus.EX_ld = 1; bus.EX_rd = 5'd5; bus.D_rs1 = 5'd5; bus.D_use_rs1 = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b101000) begin n_err++; $display("FAIL lu_rs1 got %b want %b", outs, 6'b101000); end
        tick();
        bus.EX_rd = 5'd0; bus.D_rs1 = 5'd0;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL lu_x0 got %b want %b", outs, 6'b000000); end
        tick();
        bus.EX_rd = 5'd9; bus.D_rs1 = 5'd3; bus.D_rs2 = 5'd9; bus.D_use_rs2 = 0;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL lu_rs2_unused got %b want %b", outs, 6'b000000); end
        bus.D_use_rs2 = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b101000) begin n_err++; $display("FAIL lu_rs2 got %b want %b", outs, 6'b101000); end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.stall_cycles !== 32'd2) begin n_err++; $display("FAIL lu_cnt got %0d want 2", bus.stall_cycles); end
    endtask

    task automatic test_mul;
        logic [5:0] pat;
        pat = 6'b110110;
        tick();
        bus.EX_mul = 1;
        for (int i = 5; i >= 0; i--) begin
            #1;
            n_cmp++;
            if (outs !== (pat[i] ? 6'b100101 : 6'b000000))
                begin n_err++; $display("FAIL mul_cycle%0d got %b want busy=%b", 5 - i, outs, pat[i]); end
            tick();
        end
        bus.EX_mul = 0;
        bus.EX_ld = 1; bus.EX_rd = 5'd7; bus.D_rs2 = 5'd7; bus.D_use_rs2 = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b101000) begin n_err++; $display("FAIL mul_done_lu got %b want %b", outs, 6'b101000); end
        bus.EX_mul = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b100101) begin n_err++; $display("FAIL mul_over_lu got %b want %b", outs, 6'b100101); end
        tick(); tick(); tick();
        clear_inputs();
    endtask

    task automatic test_dmiss;
        logic [31:0] base;
        tick();
        bus.MEM_dmiss = 1;
        #1;
        base = bus.stall_cycles;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) bus.MEM_dmiss = 0;
            if (i == 4) bus.MEM_fill_done = 1;
            #1;
            n_cmp++;
            if (outs !== 6'b100100) begin n_err++; $display("FAIL dmiss_cycle%0d got %b want %b", i, outs, 6'b100100); end
            tick();
        end
        bus.MEM_fill_done = 0; bus.MEM_dmiss = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL dmiss_resume got %b want %b", outs, 6'b000000); end
        n_cmp++;
        if (bus.stall_cycles - base !== 32'd5) begin n_err++; $display("FAIL dmiss_cnt got %0d want 5", bus.stall_cycles - base); end
        tick();
        bus.MEM_dmiss = 0;
        tick();
        bus.MEM_dmiss = 1; bus.MEM_fill_done = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b100100) begin n_err++; $display("FAIL samecyc_miss got %b want %b", outs, 6'b100100); end
        tick();
        bus.MEM_dmiss = 0; bus.MEM_fill_done = 0;
        #1;
        n_cmp++;
        if (outs !== 6'b100100) begin n_err++; $display("FAIL samecyc_wait got %b want %b", outs, 6'b100100); end
        tick();
        bus.MEM_fill_done = 1;
        tick();
        bus.MEM_fill_done = 0;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL samecyc_resume got %b want %b", outs, 6'b000000); end
        tick();
        clear_inputs();
    endtask

    task automatic test_redirect_deferred;
        tick();
        bus.MEM_dmiss = 1;
        tick();
        bus.MEM_dmiss = 0; bus.EX_taken_raw = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b100100) begin n_err++; $display("FAIL redir_wait got %b want %b", outs, 6'b100100); end
        tick();
        bus.MEM_fill_done = 1;
        tick();
        bus.MEM_fill_done = 0;
        #1;
        n_cmp++;
        if (outs !== 6'b010010) begin n_err++; $display("FAIL redir_resume got %b want %b", outs, 6'b010010); end
        tick();
        clear_inputs();
    endtask

    task automatic test_priority;
        tick();
        bus.EX_taken_raw = 1; bus.EX_ld = 1; bus.EX_rd = 5'd12; bus.D_rs1 = 5'd12; bus.D_use_rs1 = 1;
        bus.F_imiss = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b010010) begin n_err++; $display("FAIL redir_over_lu got %b want %b", outs, 6'b010010); end
        bus.EX_taken_raw = 0;
        #1;
        n_cmp++;
        if (outs !== 6'b101000) begin n_err++; $display("FAIL lu_over_imiss got %b want %b", outs, 6'b101000); end
        bus.EX_ld = 0;
        #1;
        n_cmp++;
        if (outs !== 6'b110000) begin n_err++; $display("FAIL imiss got %b want %b", outs, 6'b110000); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        tick();
        bus.EX_mul = 1;
        tick();
        bus.MEM_dmiss = 1;
        tick();
        bus.MEM_dmiss = 0; bus.EX_taken_raw = 1;
        #1;
        n_cmp++;
        if (outs !== 6'b100101) begin n_err++; $display("FAIL mid_wait got %b want %b", outs, 6'b100101); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL mid_rst_outs got %b want %b", outs, 6'b000000); end
        n_cmp++;
        if (bus.stall_cycles !== 32'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", bus.stall_cycles); end
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 6'b000000) begin n_err++; $display("FAIL mid_idle got %b want %b", outs, 6'b000000); end
        tick();
        bus.EX_mul = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (outs !== ((i < 2) ? 6'b100101 : 6'b000000))
                begin n_err++; $display("FAIL mid_mul%0d got %b want busy=%0d", i, outs, (i < 2)); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mul();
        test_dmiss();
        test_redirect_deferred();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage core. It drives the hold, bubble and flush controls of the F->D and D->EX pipeline registers. Inputs are load-use hazards, multi-cycle multiply occupancy in EX, data-cache misses in MEM, instruction-cache misses in F and EX branch redirects. It guarantees that the D->EX register never receives a bubble or flush while it is being held, because bubble/flush override hold in that register.

Parameters:
MUL_LAT, 3, cycles a MUL instruction occupies EX (1 = single-cycle, no stall); legal range 1..15
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset, active-low
D_rs1  in  5  source register 1 of instruction in D
D_rs2  in  5  source register 2 of instruction in D
D_use_rs1  in  1  D instruction reads rs1
D_use_rs2  in  1  D instruction reads rs2
EX_rd  in  5  destination register of instruction in EX
EX_ld  in  1  EX instruction is a load
EX_mul  in  1  EX instruction is a multiply
EX_taken_raw  in  1  EX branch resolved as mispredicted/redirect
MEM_dmiss  in  1  MEM-stage data-cache miss, level, valid in the cycle it occurs
MEM_fill_done  in  1  one-cycle pulse: miss data returned
F_imiss  in  1  fetch instruction-cache miss, level
stall_F  out  1  hold PC and F->D register
flush_FD  out  1  load a bubble into F->D register
stall_D  out  1  load a bubble into D->EX register
MEM_stall  out  1  hold D->EX, EX->MEM registers
EX_taken  out  1  qualified redirect/flush to D->EX register and PC mux
mul_busy  out  1  multiplier occupied, EX held
stall_cycles  out  CNT_W  count of cycles with stall_F=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, FSM=IDLE, mul_cnt=0 and stall_cycles=0. All outputs then evaluate to 0, and the input-driven combinational terms are masked during reset.
- Dmiss FSM, states IDLE, WAIT, RESUME:
  - IDLE -> WAIT when MEM_dmiss=1.
  - WAIT -> RESUME on MEM_fill_done.
  - RESUME -> IDLE unconditionally.
  - MEM_dmiss is ignored in RESUME, because a stale miss flag must not retrigger.
  - If MEM_dmiss and MEM_fill_done arrive in the same IDLE cycle, the miss takes effect and the fill is ignored.
- mem_hold = (state==IDLE && MEM_dmiss) || state==WAIT. It is combinational, so the stall begins in the miss cycle. There is no stall in RESUME.
- Multiply counter mul_cnt, width 4:
  - mul_busy = EX_mul && mul_cnt < MUL_LAT-1.
  - mul_cnt increments when mul_busy && !mem_hold.
  - mul_cnt clears to 0 when EX_mul && mul_cnt==MUL_LAT-1 && !mem_hold, which is the instruction advancing.
  - Result: a MUL stays in EX exactly MUL_LAT cycles absent misses. Back-to-back MULs each take MUL_LAT cycles. A miss freezes the count.
- MEM_stall = mem_hold || mul_busy.
- load_use = EX_ld && EX_rd!=0 && ((D_use_rs1 && D_rs1==EX_rd) || (D_use_rs2 && D_rs2==EX_rd)).
- Output priority, highest first:
  1. MEM_stall=1: stall_F=1, stall_D=0, EX_taken=0, flush_FD=0. The redirect is deferred, and is seen again after the hold because the EX instruction is held.
  2. EX_taken_raw=1: EX_taken=1, flush_FD=1, stall_F=0, stall_D=0. Load-use and imiss are suppressed because F and D hold wrong-path instructions.
  3. load_use=1: stall_F=1, stall_D=1, flush_FD=0.
  4. F_imiss=1: stall_F=1, flush_FD=1.
  5. Otherwise all outputs are 0.
- Invariant: stall_D and MEM_stall are never both 1, and EX_taken and MEM_stall are never both 1.
- Latency: all control outputs are combinational from inputs and current state. State and counters update on the posedge.
- stall_cycles increments on every posedge where stall_F=1. It wraps modulo 2^CNT_W and is not saturating.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - dmiss state encoding: IDLE=2'd0, WAIT=2'd1, RESUME=2'd2.
  - Register-index width constant REG_W=5.
- One sub-module: mul_occupancy_ctr. It holds mul_cnt and generates mul_busy, parameterised by MUL_LAT, with inputs EX_mul and freeze (mem_hold).
- The FSM, hazard compare and priority mux stay in the top module.

Test Plan:
- Load-use: EX_ld=1, EX_rd=5, D_rs1=5, D_use_rs1=1 for one cycle -> stall_F=1, stall_D=1 that cycle. Same stimulus with EX_rd=0 -> no stall.
- MUL_LAT=3, single MUL in EX -> mul_busy=1 for 2 cycles, then 0. MEM_stall pattern 1,1,0. A second consecutive MUL repeats the pattern 1,1,0.
- MEM_dmiss for 1 cycle, MEM_fill_done 4 cycles later -> MEM_stall=1 for 5 cycles (miss cycle plus 4 WAIT cycles). The RESUME cycle has MEM_stall=0 while MEM_dmiss=1 is still high. stall_cycles=5.
- EX_taken_raw=1 during WAIT -> EX_taken=0. On the RESUME cycle with EX_taken_raw still 1 -> EX_taken=1, flush_FD=1.
- EX_taken_raw and load_use together -> EX_taken=1, flush_FD=1, stall_D=0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during WAIT with mul_cnt=1.
  - Response: all outputs 0 immediately without a clock edge; the counter reads 0.
  - After release: FSM=IDLE, and a new MUL again stalls 2 cycles.
